ghost_rand_dir: RTL and testbench

//  Consumer end of the frame-rate LFSR random source. Once per tile-centre event, picks a frightened-mode ghost direction.

---
 rtl/pacman_pkg.sv | 32 +++
 rtl/dir_prio_pick.sv | 22 ++
 rtl/ghost_rand_dir.sv | 136 +++++++++++++
 tb/tb_ghost_rand_dir.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man game definitions: direction encoding, ghost random-direction
// FSM states, the fixed direction priority order and small helper functions.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        CHECK,
        DONE
    } ghost_rand_state_t;

    // Order in which directions are preferred when no random choice is used
    localparam dir_t PRIO [4] = '{UP, LEFT, DOWN, RIGHT};

    // Opposite direction: UP<->DOWN, LEFT<->RIGHT
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Number of open directions in a 4-bit mask
    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/dir_prio_pick.sv
// Picks the first open direction of a 4-bit mask in the fixed priority order
// UP, LEFT, DOWN, RIGHT; 'any' flags that at least one direction is open.
module dir_prio_pick
    import pacman_pkg::*;
(
    input  logic [3:0] mask,
    output logic [1:0] dir,
    output logic       any
);

    // Scan from lowest to highest priority so the highest-priority hit wins
    always_comb begin
        dir = 2'(UP);
        any = |mask;
        for (int i = 3; i >= 0; i--) begin
            if (mask[PRIO[i]]) begin
                dir = PRIO[i];
            end
        end
    end

endmodule

// File: rtl/ghost_rand_dir.sv
// Frightened-mode ghost direction chooser. On each tile-centre start it draws
// random candidates from the frame LFSR, rejecting walls and reversal, and
// falls back to fixed priority after MAX_TRIES unsuccessful draws.
module ghost_rand_dir
    import pacman_pkg::*;
#(
    parameter int MAX_TRIES = 4,
    parameter int RND_W     = 4
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       legal_mask,
    input  logic [1:0]       cur_dir,
    input  logic [RND_W-1:0] rnd,
    output logic             rnd_en,
    output logic [1:0]       dir_out,
    output logic             valid,
    output logic             stuck,
    output logic             busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    ghost_rand_state_t state, next_state;

    logic [3:0]    eff_q, next_eff;
    logic [TW-1:0] tries, next_tries, tries_inc;
    logic [1:0]    next_dir;
    logic          next_stuck;

    logic [3:0] rev_hot;
    logic [3:0] no_rev;
    logic [3:0] eff_in;
    logic [3:0] pick_mask;
    logic [1:0] pick_dir;
    logic       pick_any;
    logic [1:0] cand;
    logic       unused_rnd;

    assign cand       = rnd[1:0];
    assign unused_rnd = ^rnd[RND_W-1:2];

    // Open directions excluding reversal; a dead end allows turning back
    always_comb begin
        rev_hot = 4'b0001 << reverse_dir(dir_t'(cur_dir));
        no_rev  = legal_mask & ~rev_hot;
        eff_in  = (no_rev == 4'b0000) ? legal_mask : no_rev;
    end

    // One priority picker serves both the single-exit bypass and the fallback
    assign pick_mask = (state == IDLE) ? eff_in : eff_q;

    dir_prio_pick u_pick (
        .mask (pick_mask),
        .dir  (pick_dir),
        .any  (pick_any)
    );

    assign tries_inc = tries + TW'(1);

    // Next-state and decision logic
    always_comb begin
        next_state = state;
        next_eff   = eff_q;
        next_tries = tries;
        next_dir   = dir_out;
        next_stuck = stuck;
        case (state)
            IDLE: begin
                if (start) begin
                    next_eff   = eff_in;
                    next_tries = '0;
                    if (!pick_any) begin
                        next_state = DONE;
                        next_stuck = 1'b1;
                        next_dir   = cur_dir;
                    end else if (popcount4(eff_in) == 3'd1) begin
                        next_state = DONE;
                        next_stuck = 1'b0;
                        next_dir   = pick_dir;
                    end else begin
                        next_state = DRAW;
                    end
                end
            end
            DRAW: begin
                next_state = CHECK;
            end
            CHECK: begin
                if (eff_q[cand]) begin
                    next_state = DONE;
                    next_stuck = 1'b0;
                    next_dir   = cand;
                end else begin
                    next_tries = tries_inc;
                    if (tries_inc == TW'(MAX_TRIES)) begin
                        next_state = DONE;
                        next_stuck = 1'b0;
                        next_dir   = pick_dir;
                    end else begin
                        next_state = DRAW;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, latched mask, try counter and registered result
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            eff_q   <= '0;
            tries   <= '0;
            dir_out <= 2'(UP);
            stuck   <= 1'b0;
        end else begin
            state   <= next_state;
            eff_q   <= next_eff;
            tries   <= next_tries;
            dir_out <= next_dir;
            stuck   <= next_stuck;
        end
    end

    assign rnd_en = (state == DRAW);
    assign valid  = (state == DONE);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ghost_rand_dir.sv
// Self-checking bench for ghost_rand_dir: table of directed operations plus
// hand-written reset-abort and start-while-busy sequences.
module tb_ghost_rand_dir;

    logic       frame_clk;
    logic       Reset;
    logic       start;
    logic [3:0] legal_mask;
    logic [1:0] cur_dir;
    logic [3:0] rnd;
    logic       rnd_en;
    logic [1:0] dir_out;
    logic       valid;
    logic       stuck;
    logic       busy;

    int checks;
    int failures;

    typedef struct {
        string      name;
        logic [3:0] legal;
        logic [1:0] cur;
        logic [3:0] rnd;
        logic [1:0] exp_dir;
        logic       exp_stuck;
        int         exp_lat;
        int         exp_draws;
    } vec_t;

    vec_t vecs [9];

    ghost_rand_dir #(.MAX_TRIES(4), .RND_W(4)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .start      (start),
        .legal_mask (legal_mask),
        .cur_dir    (cur_dir),
        .rnd        (rnd),
        .rnd_en     (rnd_en),
        .dir_out    (dir_out),
        .valid      (valid),
        .stuck      (stuck),
        .busy       (busy)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one operation, scrambles the live inputs after acceptance and
    // waits (bounded) for valid; reports latency, draw count and result
    task automatic apply_stimulus(input vec_t v, output int lat, output int draws,
                                  output int got_dir, output int got_stuck,
                                  output int extra_valid);
        @(negedge frame_clk);
        legal_mask = v.legal;
        cur_dir    = v.cur;
        rnd        = v.rnd;
        start      = 1'b1;
        lat        = 0;
        draws      = 0;
        got_dir    = -1;
        got_stuck  = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge frame_clk);
            if (c == 1) begin
                start      = 1'b0;
                legal_mask = ~v.legal;
                cur_dir    = ~v.cur;
            end
            if (rnd_en) draws++;
            if (valid) begin
                lat       = c;
                got_dir   = int'(dir_out);
                got_stuck = int'(stuck);
                break;
            end
        end
        @(negedge frame_clk);
        extra_valid = int'(valid);
    endtask

    initial begin
        int lat, draws, gdir, gstuck, xvalid, nvalid, vdir;

        checks   = 0;
        failures = 0;

        //            name         legal    cur    rnd      dir    stuck lat draws
        vecs[0] = '{"all_fb",   4'b1111, 2'd0, 4'b0110, 2'd0, 1'b0, 9, 4};
        vecs[1] = '{"hit_down", 4'b1111, 2'd1, 4'b0110, 2'd2, 1'b0, 3, 1};
        vecs[2] = '{"hi_bits",  4'b1111, 2'd1, 4'b1110, 2'd2, 1'b0, 3, 1};
        vecs[3] = '{"bypass_l", 4'b1010, 2'd1, 4'b0011, 2'd1, 1'b0, 1, 0};
        vecs[4] = '{"deadend",  4'b0100, 2'd0, 4'b0000, 2'd2, 1'b0, 1, 0};
        vecs[5] = '{"fallback", 4'b1100, 2'd3, 4'b0000, 2'd2, 1'b0, 9, 4};
        vecs[6] = '{"stuck",    4'b0000, 2'd3, 4'b0001, 2'd3, 1'b1, 1, 0};
        vecs[7] = '{"bypass_u", 4'b0011, 2'd3, 4'b0010, 2'd0, 1'b0, 1, 0};
        vecs[8] = '{"hit_right",4'b1110, 2'd2, 4'b0011, 2'd3, 1'b0, 3, 1};

        Reset      = 1'b1;
        start      = 1'b0;
        legal_mask = 4'b0000;
        cur_dir    = 2'd0;
        rnd        = 4'b0000;

        repeat (2) @(negedge frame_clk);
        check_output("reset_rnd_en", int'(rnd_en), 0);
        check_output("reset_valid", int'(valid), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_stuck", int'(stuck), 0);
        check_output("reset_dir", int'(dir_out), 0);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], lat, draws, gdir, gstuck, xvalid);
            check_output({vecs[i].name, "_dir"}, gdir, int'(vecs[i].exp_dir));
            check_output({vecs[i].name, "_stuck"}, gstuck, int'(vecs[i].exp_stuck));
            check_output({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            check_output({vecs[i].name, "_draws"}, draws, vecs[i].exp_draws);
            check_output({vecs[i].name, "_one_valid"}, xvalid, 0);
        end

        // Reset asserted while in DRAW aborts the operation at once
        @(negedge frame_clk);
        legal_mask = 4'b1100;
        cur_dir    = 2'd3;
        rnd        = 4'b0000;
        start      = 1'b1;
        @(negedge frame_clk);
        start = 1'b0;
        check_output("abort_in_draw", int'(rnd_en), 1);
        Reset = 1'b1;
        #1;
        check_output("abort_rnd_en", int'(rnd_en), 0);
        check_output("abort_busy", int'(busy), 0);
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset  = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge frame_clk);
            if (valid) nvalid++;
        end
        check_output("abort_no_valid", nvalid, 0);

        // Start held high while busy yields exactly one result
        legal_mask = 4'b1110;
        cur_dir    = 2'd2;
        rnd        = 4'b0011;
        start      = 1'b1;
        nvalid     = 0;
        vdir       = -1;
        for (int c = 0; c < 15; c++) begin
            @(negedge frame_clk);
            if (valid) begin
                nvalid++;
                vdir  = int'(dir_out);
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_output("busy_start_one_valid", nvalid, 1);
        check_output("busy_start_dir", vdir, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
